// File: rtl/sm4_dec_if.sv
// Pipeline-side handshake bundle for the SM4 decryption sequencing controller.
// slave = controller side, master = pipeline/testbench side.
interface sm4_dec_if #(
  parameter int CNT_W = 6
);
  logic             valid_in;
  logic             key_ready;
  logic             hold_pipline;
  logic             save_data;
  logic             round_en;
  logic [4:0]       rk_index;
  logic [CNT_W-1:0] counter;
  logic             busy;
  logic             abort;

  modport master (
    output valid_in,
    output key_ready,
    input  hold_pipline,
    input  save_data,
    input  round_en,
    input  rk_index,
    input  counter,
    input  busy,
    input  abort
  );

  modport slave (
    input  valid_in,
    input  key_ready,
    output hold_pipline,
    output save_data,
    output round_en,
    output rk_index,
    output counter,
    output busy,
    output abort
  );
endinterface

// File: rtl/sm4_dec_controller.sv
// SM4 decrypt sequencer: stalls the pipeline, walks 32 rounds with reverse key index, strobes the result.
// Optional cancel-on-valid-drop behaviour is enabled by defining SM4_DEC_ABORT_EN.
module sm4_dec_controller #(
  parameter int ROUNDS = 32,
  parameter int CNT_W  = 6
) (
  input  logic       clk,
  input  logic       rest,
  sm4_dec_if.slave   bus
);

`ifdef SM4_DEC_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_KEY = 2'd1,
    ROUND    = 2'd2,
    SAVE     = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_counter;
  logic [CNT_W-1:0] w_next_counter;
  logic             w_hold;
  logic             w_save;
  logic             w_round_en;
  logic [4:0]       w_rk_index;
  logic             w_abort;

  // State register and round counter
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      r_state   <= IDLE;
      r_counter <= {CNT_W{1'b0}};
    end else begin
      r_state   <= w_next_state;
      r_counter <= w_next_counter;
    end
  end

  // Next-state, counter update and combinational outputs
  always_comb begin
    w_next_state   = r_state;
    w_next_counter = r_counter;
    w_hold         = 1'b0;
    w_save         = 1'b0;
    w_round_en     = 1'b0;
    w_rk_index     = 5'd0;
    w_abort        = 1'b0;

    case (r_state)
      IDLE: begin
        w_hold         = bus.valid_in;
        w_next_counter = {CNT_W{1'b0}};
        if (bus.valid_in) begin
          if (bus.key_ready) begin
            w_next_state = ROUND;
          end else begin
            w_next_state = WAIT_KEY;
          end
        end else begin
          w_next_state = IDLE;
        end
      end

      WAIT_KEY: begin
        w_hold = 1'b1;
        if (ABORT_EN && !bus.valid_in) begin
          w_abort        = 1'b1;
          w_next_state   = IDLE;
          w_next_counter = {CNT_W{1'b0}};
        end else if (bus.key_ready) begin
          w_next_state = ROUND;
        end else begin
          w_next_state = WAIT_KEY;
        end
      end

      ROUND: begin
        w_hold     = 1'b1;
        w_round_en = 1'b1;
        w_rk_index = 5'd31 - r_counter[4:0];
        // key_ready is deliberately not consulted once rounds are running
        if (ABORT_EN && !bus.valid_in) begin
          w_abort        = 1'b1;
          w_next_state   = IDLE;
          w_next_counter = {CNT_W{1'b0}};
        end else begin
          w_next_counter = r_counter + {{(CNT_W-1){1'b0}}, 1'b1};
          if (r_counter == CNT_W'(ROUNDS - 1)) begin
            w_next_state = SAVE;
          end else begin
            w_next_state = ROUND;
          end
        end
      end

      SAVE: begin
        w_save         = 1'b1;
        w_next_state   = IDLE;
        w_next_counter = {CNT_W{1'b0}};
      end

      default: begin
        w_next_state   = IDLE;
        w_next_counter = {CNT_W{1'b0}};
      end
    endcase
  end

  assign bus.hold_pipline = w_hold;
  assign bus.save_data    = w_save;
  assign bus.round_en     = w_round_en;
  assign bus.rk_index     = w_rk_index;
  assign bus.counter      = r_counter;
  assign bus.busy         = (r_state != IDLE);
  assign bus.abort        = w_abort;

endmodule

// File: tb/tb_sm4_dec_controller.sv
// Testbench for sm4_dec_controller: directed timing scenarios plus random stimulus,
// every cycle compared against an operation-level reference model.
module tb_sm4_dec_controller;

  localparam int RND = 32;

  logic clk;
  logic rest;
  int   n_checks;
  int   n_errors;
  int   cyc;
  int   saves[$];
  int   t0;

  // Reference model: one in-flight operation, described by progress rather than FSM state
  bit   m_active;
  bit   m_keyed;
  int   m_done;

  sm4_dec_if #(.CNT_W(6)) bus ();

  sm4_dec_controller #(.ROUNDS(RND), .CNT_W(6)) dut (
    .clk  (clk),
    .rest (rest),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit model_abort(input logic v);
`ifdef SM4_DEC_ABORT_EN
    return m_active && (m_done < RND) && !v;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_outputs();
    logic       e_hold, e_save, e_ren, e_busy, e_abort;
    logic [4:0] e_rk;
    int         e_cnt;
    e_save  = 1'b0;
    e_ren   = 1'b0;
    e_rk    = 5'd0;
    e_cnt   = 0;
    e_busy  = m_active;
    e_abort = model_abort(bus.valid_in);
    if (!m_active) begin
      e_hold = bus.valid_in;
    end else if (!m_keyed) begin
      e_hold = 1'b1;
    end else if (m_done < RND) begin
      e_hold = 1'b1;
      e_ren  = 1'b1;
      e_rk   = 5'(31 - m_done);
      e_cnt  = m_done;
    end else begin
      e_hold = 1'b0;
      e_save = 1'b1;
      e_cnt  = RND;
    end
    check_eq("hold_pipline", 32'(bus.hold_pipline), 32'(e_hold));
    check_eq("save_data",    32'(bus.save_data),    32'(e_save));
    check_eq("round_en",     32'(bus.round_en),     32'(e_ren));
    check_eq("rk_index",     32'(bus.rk_index),     32'(e_rk));
    check_eq("counter",      32'(bus.counter),      32'(e_cnt));
    check_eq("busy",         32'(bus.busy),         32'(e_busy));
    check_eq("abort",        32'(bus.abort),        32'(e_abort));
  endtask

  task automatic model_advance(input logic v, input logic k);
    if (!m_active) begin
      if (v) begin
        m_active = 1'b1;
        m_keyed  = k;
        m_done   = 0;
      end
    end else if (model_abort(v)) begin
      m_active = 1'b0;
      m_keyed  = 1'b0;
      m_done   = 0;
    end else if (!m_keyed) begin
      m_keyed = k;
    end else if (m_done < RND) begin
      m_done++;
    end else begin
      m_active = 1'b0;
      m_keyed  = 1'b0;
      m_done   = 0;
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model on the edge
  task automatic step(input logic v, input logic k, input logic r);
    @(negedge clk);
    bus.valid_in  = v;
    bus.key_ready = k;
    rest          = r;
    #1;
    if (!r) begin
      m_active = 1'b0;
      m_keyed  = 1'b0;
      m_done   = 0;
    end
    check_outputs();
    if (bus.save_data) saves.push_back(cyc);
    @(posedge clk);
    if (r) model_advance(v, k);
    cyc++;
  endtask

  initial begin
    logic rv, rk, rr;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    m_active = 1'b0;
    m_keyed  = 1'b0;
    m_done   = 0;
    rest          = 1'b0;
    bus.valid_in  = 1'b0;
    bus.key_ready = 1'b0;

    repeat (3) step(1'b0, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b1, 1'b1);

    // Basic request with key already loaded
    saves.delete();
    t0 = cyc;
    for (int i = 0; i <= 33; i++) step(1'b1, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1, 1'b1);
    check_eq("basic_nsave", 32'(saves.size()), 32'd1);
    if (saves.size() > 0) check_eq("basic_lat", 32'(saves[0] - t0), 32'd33);

    // Key schedule late by three cycles
    saves.delete();
    t0 = cyc;
    for (int i = 0; i <= 36; i++) step(1'b1, (i >= 3) ? 1'b1 : 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b1);
    check_eq("waitkey_nsave", 32'(saves.size()), 32'd1);
    if (saves.size() > 0) check_eq("waitkey_lat", 32'(saves[0] - t0), 32'd36);

    // Back-to-back operations with valid_in held high
    saves.delete();
    t0 = cyc;
    for (int i = 0; i <= 67; i++) step(1'b1, 1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b1, 1'b1);
    check_eq("b2b_nsave", 32'(saves.size()), 32'd2);
    if (saves.size() > 1) begin
      check_eq("b2b_first",  32'(saves[0] - t0), 32'd33);
      check_eq("b2b_second", 32'(saves[1] - t0), 32'd67);
    end

    // Reset in the middle of the rounds, then a clean request
    saves.delete();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b1, 1'b1);
    check_eq("rst_nsave", 32'(saves.size()), 32'd0);
    t0 = cyc;
    for (int i = 0; i <= 33; i++) step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check_eq("rst_after_nsave", 32'(saves.size()), 32'd1);
    if (saves.size() > 0) check_eq("rst_after_lat", 32'(saves[0] - t0), 32'd33);

    // valid_in dropped at round cycle 5
    saves.delete();
    t0 = cyc;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1);
    repeat (40) step(1'b0, 1'b1, 1'b1);
`ifdef SM4_DEC_ABORT_EN
    check_eq("drop_nsave", 32'(saves.size()), 32'd0);
`else
    check_eq("drop_nsave", 32'(saves.size()), 32'd1);
    if (saves.size() > 0) check_eq("drop_lat", 32'(saves[0] - t0), 32'd33);
`endif

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (!m_active) rv = ($urandom_range(0, 2) != 0);
      else           rv = ($urandom_range(0, 59) != 0);
      rk = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 249) != 0);
      step(rv, rk, rr);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sm4_dec_controller.md
# sm4_dec_controller

Sequencing controller for the SM4 decryption path of the encryption accelerator: it accepts a decrypt request held by the core pipeline, stalls the pipeline, and walks the 32 SM4 rounds with the round-key index running in reverse (rk31 down to rk0). On completion it pulses a result-capture strobe and releases the pipeline. It sits beside the encryption controller and drives the same round datapath, key schedule RAM, and hold/save interface toward the zero-riscy pipeline.

## Interface
- ROUNDS, 32, number of SM4 rounds; fixed by the algorithm, exposed only for reduced-round test builds.
- CNT_W, 6, width of `counter`; must hold the value ROUNDS.
- clk  in  1  single clock domain, rising edge.
- rest  in  1  asynchronous, active-low reset.
- valid_in  in  1  decrypt instruction present in the execute stage; held high while the pipeline is stalled.
- key_ready  in  1  round-key schedule is loaded and valid.
- hold_pipline  out  1  stall request to the core pipeline.
- save_data  out  1  one-cycle strobe: capture the datapath result into the destination register.
- round_en  out  1  round datapath advances this cycle.
- rk_index  out  5  round-key read index.
- counter  out  CNT_W  rounds completed in the current operation.
- busy  out  1  high in any state other than IDLE.
- abort  out  1  one-cycle pulse when an operation is cancelled (SM4_DEC_ABORT_EN only; tied 0 otherwise).

## Operation
- States: IDLE, WAIT_KEY, ROUND, SAVE. One state register plus the counter. All other outputs are combinational from state, counter, and valid_in.
- IDLE: `hold_pipline = valid_in`, so the stall takes effect in the same cycle. If `valid_in` is high, go to ROUND when `key_ready` is high, otherwise go to WAIT_KEY.
- WAIT_KEY: `hold_pipline = 1`. Go to ROUND when `key_ready` is high.
- ROUND: `hold_pipline = 1`, `round_en = 1`, `rk_index = 31 - counter[4:0]`. The counter increments every cycle. When `counter == ROUNDS-1`, go to SAVE; the counter becomes ROUNDS.
- SAVE: `save_data = 1`, `hold_pipline = 0`, `counter == ROUNDS`. Always go to IDLE next, and clear the counter to 0.
- In every state other than ROUND, `rk_index = 0` and `round_en = 0`.
- The counter is an unsigned CNT_W-bit value and never wraps. Its maximum value is ROUNDS.
- `key_ready` is sampled only in IDLE and WAIT_KEY. A drop of `key_ready` during ROUND is ignored.
- Reset values (`rest` low): state IDLE, counter 0. Outputs under reset: `save_data`, `round_en`, `busy`, and `abort` are 0; `rk_index` is 0; `hold_pipline` equals `valid_in`.
- Reset asserted mid-operation returns the block to IDLE immediately and clears the counter. No `save_data` and no `abort` is produced.

## Timing
- Request in IDLE with `key_ready = 1` at cycle 0:
  - ROUND in cycles 1..32, with `rk_index` 31, 30, …, 0.
  - SAVE in cycle 33.
  - The pipeline advances at the end of cycle 33.
- Each IDLE-to-ROUND transition through WAIT_KEY adds one cycle per cycle that `key_ready` is low.
- Back-to-back requests: if `valid_in` is high in the cycle after SAVE, that is a new instruction and starts a new operation from IDLE. There are no dead cycles beyond the single IDLE cycle.
- `hold_pipline` is low in exactly one cycle of a completed operation (SAVE), apart from IDLE with `valid_in` low.

## Configuration
- Macro: SM4_DEC_ABORT_EN.
- Defined:
  - `valid_in` low in WAIT_KEY or ROUND forces the next state to IDLE and clears the counter.
  - `abort` is high in that cycle.
  - `save_data` is not asserted for the cancelled operation.
  - `valid_in` low in SAVE has no effect.
- Not defined:
  - After leaving IDLE, `valid_in` is ignored until the operation completes.
  - `abort` is constant 0.

## Test plan
- Reset with `valid_in = 0`, then release: `hold_pipline = 0`, `busy = 0`, `counter = 0`, `rk_index = 0` in all idle cycles.
- `valid_in = 1`, `key_ready = 1` at cycle 0:
  - `hold_pipline` is high in cycles 0..32.
  - `rk_index` is 31 in cycle 1 and 0 in cycle 32.
  - `save_data = 1` and `counter = 32` in cycle 33, with `hold_pipline = 0`.
- `key_ready` low for 3 cycles after the request: WAIT_KEY for 3 cycles, first ROUND in cycle 4, `save_data` in cycle 36.
- Back-to-back: `valid_in` high continuously across two operations. `save_data` pulses in cycles 33 and 67, and `rk_index` restarts at 31.
- `rest` asserted in cycle 10 of ROUND: state IDLE, `counter = 0`, no `save_data`. A new request after release completes normally in 34 cycles.
- With SM4_DEC_ABORT_EN defined, `valid_in` dropped at ROUND cycle 5: `abort = 1` that cycle, IDLE next, no `save_data`. Without the macro, the same stimulus still produces `save_data` in cycle 33.
